// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding plus load-use bubble / data-memory freeze control for the 5-stage pipe.
// Define PERF_CNT_EN to build the stall-cycle counter; otherwise stall_cycles reads as zero.
//
//  state  | meaning
//  S_RUN  | normal issue; load-use check, first bubble injected here
//  S_LU   | remaining load-use bubbles, r_cnt counts them down
//  S_WAIT | whole pipe frozen on data memory, r_cnt keeps the pending bubbles
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int N_SRC    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC*REG_AW-1:0]   id_src,
    input  logic [N_SRC-1:0]          id_src_used,
    input  logic [N_SRC*REG_AW-1:0]   ex_src,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         ex_wr,
    input  logic                      m_regwrite,
    input  logic [REG_AW-1:0]         m_wr,
    input  logic                      m_memaccess,
    input  logic                      dmem_ready,
    input  logic                      wb_regwrite,
    input  logic [REG_AW-1:0]         wb_wr,
    output logic [2*N_SRC-1:0]        fwd_sel,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      idex_flush,
    output logic                      pipe_freeze,
    output logic [31:0]               stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LU   = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_eff;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_nxt;
    logic [2*N_SRC-1:0]  w_fwd;
    logic                w_hz;
    logic                w_mem_wait;
    logic                w_pc_write;
    logic                w_ifid_write;
    logic                w_idex_flush;
    logic                w_pipe_freeze;

    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (ex_src[i*REG_AW +: REG_AW] != '0) begin
                if (m_regwrite && (m_wr == ex_src[i*REG_AW +: REG_AW]))
                    w_fwd[2*i +: 2] = 2'b10;
                else if (wb_regwrite && (wb_wr == ex_src[i*REG_AW +: REG_AW]))
                    w_fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    assign fwd_sel = w_fwd;

    always_comb begin
        w_hz = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == ex_wr))
                w_hz = 1'b1;
        end
        w_hz = w_hz & ex_memread & (ex_wr != '0);
    end

    assign w_mem_wait = m_memaccess & ~dmem_ready;

    // The release cycle of WAIT already behaves as the state being resumed, so
    // pending bubbles are neither lost nor doubled and the hazard is re-checked at once.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_flush  = 1'b0;
        w_pipe_freeze = 1'b0;
        w_eff         = r_state;
        if ((r_state == S_WAIT) && dmem_ready)
            w_eff = (r_cnt != '0) ? S_LU : S_RUN;

        if (w_mem_wait) begin
            w_pipe_freeze = 1'b1;
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_state_nxt   = S_WAIT;
        end else begin
            case (w_eff)
                S_RUN: begin
                    w_state_nxt = S_RUN;
                    if (w_hz) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_cnt_nxt   = LU_INIT;
                            w_state_nxt = S_LU;
                        end
                    end
                end
                S_LU: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt   = r_cnt - 3'd1;
                        w_state_nxt = S_LU;
                    end
                end
                default: begin
                    w_pipe_freeze = 1'b1;
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                end
            endcase
        end

        if (!rst_n) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
            w_pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign idex_flush  = w_idex_flush;
    assign pipe_freeze = w_pipe_freeze;

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!w_pc_write && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl (LOAD_LAT = 2): forwarding, load-use bubbles, memory freeze, reset.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int N_SRC    = 2;
    localparam int LOAD_LAT = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_SRC*REG_AW-1:0]  id_src;
    logic [N_SRC-1:0]         id_src_used;
    logic [N_SRC*REG_AW-1:0]  ex_src;
    logic                     ex_memread;
    logic [REG_AW-1:0]        ex_wr;
    logic                     m_regwrite;
    logic [REG_AW-1:0]        m_wr;
    logic                     m_memaccess;
    logic                     dmem_ready;
    logic                     wb_regwrite;
    logic [REG_AW-1:0]        wb_wr;
    logic [2*N_SRC-1:0]       fwd_sel;
    logic                     pc_write;
    logic                     ifid_write;
    logic                     idex_flush;
    logic                     pipe_freeze;
    logic [31:0]              stall_cycles;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .N_SRC(N_SRC), .LOAD_LAT(LOAD_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .ex_src       (ex_src),
        .ex_memread   (ex_memread),
        .ex_wr        (ex_wr),
        .m_regwrite   (m_regwrite),
        .m_wr         (m_wr),
        .m_memaccess  (m_memaccess),
        .dmem_ready   (dmem_ready),
        .wb_regwrite  (wb_regwrite),
        .wb_wr        (wb_wr),
        .fwd_sel      (fwd_sel),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_flush   (idex_flush),
        .pipe_freeze  (pipe_freeze),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] fwd;
        logic       pc;
        logic       ifid;
        logic       flush;
        logic       frz;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int unsigned exp_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_fwd(input logic [9:0] src, input logic mrw,
                                           input logic [4:0] mwr, input logic wrw,
                                           input logic [4:0] wwr);
        logic [3:0] r;
        logic [4:0] s;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            s = src[i*5 +: 5];
            if (s != 0 && mrw && mwr == s)      r[2*i +: 2] = 2'b10;
            else if (s != 0 && wrw && wwr == s) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    // Called just after a falling edge with inputs already driven; one pipe cycle per call.
    task automatic cyc(input string tag, input logic [3:0] e_fwd, input logic e_pc,
                       input logic e_ifid, input logic e_flush, input logic e_frz);
        exp_t e;
        exp_t o;
        e.tag = tag; e.fwd = e_fwd; e.pc = e_pc; e.ifid = e_ifid; e.flush = e_flush; e.frz = e_frz;
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        chk({o.tag, ".fwd"},   32'(fwd_sel),     32'(o.fwd));
        chk({o.tag, ".pc"},    32'(pc_write),    32'(o.pc));
        chk({o.tag, ".ifid"},  32'(ifid_write),  32'(o.ifid));
        chk({o.tag, ".flush"}, 32'(idex_flush),  32'(o.flush));
        chk({o.tag, ".frz"},   32'(pipe_freeze), 32'(o.frz));
        @(posedge clk);
        #1;
        if (!rst_n)     exp_stall = 0;
        else if (!o.pc) exp_stall++;
`ifdef PERF_CNT_EN
        chk({o.tag, ".stall"}, stall_cycles, exp_stall);
`else
        chk({o.tag, ".stall"}, stall_cycles, 32'h0);
`endif
        @(negedge clk);
    endtask

    task automatic quiet();
        id_src = '0; id_src_used = '0; ex_src = '0; ex_memread = 1'b0; ex_wr = '0;
        m_regwrite = 1'b0; m_wr = '0; m_memaccess = 1'b0; dmem_ready = 1'b1;
        wb_regwrite = 1'b0; wb_wr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] a;
        logic [4:0] b;
        quiet();
        rst_n = 1'b0;
        @(negedge clk);
        cyc("reset", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc("idle", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // forwarding priority and register 0
        ex_src = {5'd0, 5'd3}; m_regwrite = 1'b1; m_wr = 5'd3; wb_regwrite = 1'b1; wb_wr = 5'd3;
        cyc("mem_wins", 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_src = {5'd7, 5'd0}; m_wr = 5'd0; wb_wr = 5'd7;
        cyc("r0_wb", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_src = {5'd7, 5'd7}; m_regwrite = 1'b0; m_wr = 5'd7;
        cyc("mem_nowr", 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_src = {5'd0, 5'd0}; wb_wr = 5'd0; m_regwrite = 1'b1; m_wr = 5'd0;
        cyc("r0_both", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3));
            ex_src = {a, b};
            m_regwrite = 1'($urandom_range(0, 1)); m_wr = 5'($urandom_range(0, 3));
            wb_regwrite = 1'($urandom_range(0, 1)); wb_wr = 5'($urandom_range(0, 3));
            cyc("fwd_rand", ref_fwd(ex_src, m_regwrite, m_wr, wb_regwrite, wb_wr),
                1'b1, 1'b1, 1'b0, 1'b0);
        end
        quiet();

        // load-use: exactly LOAD_LAT bubbles
        ex_memread = 1'b1; ex_wr = 5'd5; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        cyc("lu_b1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_memread = 1'b0; ex_wr = 5'd0;
        cyc("lu_b2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("lu_done", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // no stall: operand unused, load to r0, non-load producer
        ex_memread = 1'b1; ex_wr = 5'd5; id_src = {5'd0, 5'd5}; id_src_used = 2'b00;
        cyc("unused", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_wr = 5'd0; id_src = {5'd0, 5'd0}; id_src_used = 2'b01;
        cyc("ld_r0", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_memread = 1'b0; ex_wr = 5'd5; id_src = {5'd0, 5'd5};
        cyc("not_ld", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        quiet();

        // freeze during an LU bubble, pending bubble honoured afterwards
        ex_memread = 1'b1; ex_wr = 5'd9; id_src = {5'd9, 5'd0}; id_src_used = 2'b10;
        cyc("fz_b1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_memread = 1'b0; ex_wr = 5'd0; m_memaccess = 1'b1; dmem_ready = 1'b0;
        cyc("fz_1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("fz_2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("fz_3", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        cyc("fz_b2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        m_memaccess = 1'b0;
        cyc("fz_done", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // freeze and hazard together: freeze first, hazard re-evaluated on release
        ex_memread = 1'b1; ex_wr = 5'd4; id_src = {5'd0, 5'd4}; id_src_used = 2'b01;
        m_memaccess = 1'b1; dmem_ready = 1'b0;
        cyc("both_fz", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        cyc("both_b1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_memread = 1'b0; ex_wr = 5'd0; m_memaccess = 1'b0;
        cyc("both_b2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("both_done", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        quiet();

        // reset mid-LU
        ex_memread = 1'b1; ex_wr = 5'd6; id_src = {5'd0, 5'd6}; id_src_used = 2'b01;
        cyc("rl_b1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        quiet();
        rst_n = 1'b0;
        cyc("rl_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc("rl_run", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset mid-WAIT: freeze dropped immediately, RUN afterwards
        ex_memread = 1'b1; ex_wr = 5'd6; id_src = {5'd0, 5'd6}; id_src_used = 2'b01;
        cyc("rw_b1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_memread = 1'b0; ex_wr = 5'd0; m_memaccess = 1'b1; dmem_ready = 1'b0;
        cyc("rw_fz", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc("rw_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        quiet();
        rst_n = 1'b1;
        cyc("rw_run", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rw_idle", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
